entry_timer_ctrl: RTL

// Supervises the code-entry FSM: times each entry window, counts failed attempts and enforces a lockout.

---
 rtl/entry_timer_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/entry_timer_ctrl.sv
// Entry-window supervisor for the code-entry FSM: times each window, counts
// failure events and holds a lockout once the failure limit is reached.
module entry_timer_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCK_CYCLES    = 250_000_000,
  parameter int unsigned TW             = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       encnt,
  input  logic       anyIN,
  input  logic       unlocked,
  output logic       timeOut,
  output logic       cntOut,
  output logic [2:0] fail_cnt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WINDOW = 2'd1,
    S_LOCK   = 2'd2
  } state_t;

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] LK_LAST  = TW'(LOCK_CYCLES - 1);
  localparam logic [2:0]    FAIL_MAX = 3'(MAX_FAIL);

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_encnt_q;
  logic          r_timeout;
  logic          r_cnt_out;
  logic [2:0]    r_fail;

  logic          w_enc_rise;
  logic          w_tmo;
  logic          w_fail_evt;
  logic [2:0]    w_fail_next;

  assign w_enc_rise  = encnt & ~r_encnt_q;
  // Dropping en on the final window cycle is an exit, not a timeout.
  assign w_tmo       = (r_state == S_WINDOW) && en && !anyIN && (r_timer == TO_LAST);
  assign w_fail_evt  = (r_state != S_LOCK) && (w_enc_rise || w_tmo);
  assign w_fail_next = (r_fail >= FAIL_MAX) ? FAIL_MAX : r_fail + 3'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_fail    <= 3'd0;
      r_timeout <= 1'b0;
      r_cnt_out <= 1'b0;
      // Track encnt during reset so a level held across reset is not an edge.
      r_encnt_q <= encnt;
    end else begin
      r_encnt_q <= encnt;
      r_timeout <= w_tmo;
      case (r_state)
        S_LOCK: begin
          if (r_timer == LK_LAST) begin
            r_cnt_out <= 1'b0;
            r_fail    <= 3'd0;
            r_timer   <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          if (w_fail_evt && (w_fail_next == FAIL_MAX)) begin
            r_fail    <= w_fail_next;
            r_cnt_out <= 1'b1;
            r_timer   <= '0;
            r_state   <= S_LOCK;
          end else begin
            if (w_fail_evt)
              r_fail <= w_fail_next;
            else if (unlocked)
              r_fail <= 3'd0;

            if (w_tmo) begin
              r_state <= S_IDLE;
              r_timer <= '0;
            end else if (r_state == S_IDLE) begin
              r_timer <= '0;
              if (en) r_state <= S_WINDOW;
            end else if (!en) begin
              r_state <= S_IDLE;
              r_timer <= '0;
            end else if (anyIN) begin
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign timeOut  = r_timeout;
  assign cntOut   = r_cnt_out;
  assign fail_cnt = r_fail;
  assign state    = r_state;

endmodule
